// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential halfword fetches and queues
// up to DEPTH {instruction, pc} pairs for the decoder. A redirect flushes the
// queue and restarts fetch; a response still owed by memory is absorbed in
// DISCARD so it never reaches the queue.
module instr_prefetch_buffer #(
  parameter int unsigned            PC_WIDTH    = 32,
  parameter int unsigned            ADDR_WIDTH  = 12,
  parameter int unsigned            INSTR_WIDTH = 16,
  parameter int unsigned            DEPTH       = 4,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 16'hBF00,
  parameter int unsigned            PC_STEP     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [PC_WIDTH-1:0]      redirect_pc,
  output logic                     mem_load_request,
  output logic [ADDR_WIDTH-1:0]    mem_address,
  input  logic                     mem_output_valid,
  input  logic [INSTR_WIDTH-1:0]   mem_instruction,
  input  logic                     stall_decoder_in,
  output logic                     instruction_valid,
  output logic [INSTR_WIDTH-1:0]   instruction_out,
  output logic [PC_WIDTH-1:0]      instruction_pc,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } state_t;

  state_t                 state;
  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [ADDR_WIDTH-1:0]  discard_address;
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
  logic [PC_WIDTH-1:0]    pc_q    [DEPTH];
  logic                   push;
  logic                   pop;

  // Memory request and address decoded from the registered state and count
  always_comb begin
    mem_load_request = 1'b0;
    mem_address      = '0;
    case (state)
      FETCH: begin
        mem_load_request = (fill_level < FULL_COUNT);
        mem_address      = fetch_pc[ADDR_WIDTH:1];
      end
      DISCARD: begin
        mem_load_request = 1'b1;
        mem_address      = discard_address;
      end
      default: ;
    endcase
  end

  // Queue handshake and head presentation; a redirect hides the head
  always_comb begin
    push              = (state == FETCH) && mem_load_request && mem_output_valid && !redirect_valid;
    instruction_valid = (fill_level != '0) && !redirect_valid;
    pop               = instruction_valid && !stall_decoder_in;
    instruction_out   = instruction_valid ? instr_q[rd_ptr] : NOP_INSTR;
    instruction_pc    = instruction_valid ? pc_q[rd_ptr] : '0;
  end

  // Control state, fetch pc and queue pointers; redirect outranks push and pop
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      fetch_pc        <= '0;
      discard_address <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fill_level      <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          // The old request is still owed a response: hold its address
          if (redirect_valid && mem_load_request && !mem_output_valid) begin
            state           <= DISCARD;
            discard_address <= fetch_pc[ADDR_WIDTH:1];
          end
        end
        DISCARD: begin
          if (!redirect_valid && mem_output_valid) state <= FETCH;
        end
        default: state <= IDLE;
      endcase

      if (redirect_valid) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fill_level <= '0;
        fetch_pc   <= redirect_pc & ~PC_WIDTH'(1);
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + PTR_WIDTH'(1);
          fetch_pc <= fetch_pc + PC_WIDTH'(PC_STEP);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
        if (push && !pop)      fill_level <= fill_level + (PTR_WIDTH + 1)'(1);
        else if (pop && !push) fill_level <= fill_level - (PTR_WIDTH + 1)'(1);
      end
    end
  end

  // Queue storage; entries are only meaningful between rd_ptr and wr_ptr
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= mem_instruction;
      pc_q[wr_ptr]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Testbench for instr_prefetch_buffer: fixed vector table, directed sequences
// for flush and reset corners, and randomized traffic against a queue model.
module tb_instr_prefetch_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_load_request;
  logic [11:0] mem_address;
  logic        mem_output_valid;
  logic [15:0] mem_instruction;
  logic        stall_decoder_in;
  logic        instruction_valid;
  logic [15:0] instruction_out;
  logic [31:0] instruction_pc;
  logic [2:0]  fill_level;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(
    .PC_WIDTH(32), .ADDR_WIDTH(12), .INSTR_WIDTH(16),
    .DEPTH(DEPTH), .NOP_INSTR(16'hBF00), .PC_STEP(2)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_load_request(mem_load_request), .mem_address(mem_address),
    .mem_output_valid(mem_output_valid), .mem_instruction(mem_instruction),
    .stall_decoder_in(stall_decoder_in),
    .instruction_valid(instruction_valid), .instruction_out(instruction_out),
    .instruction_pc(instruction_pc), .fill_level(fill_level)
  );

  // Memory: mem[a] = 16'h1000 + a; either fixed wait states or random ready
  logic        use_random;
  logic        mem_rnd;
  int unsigned lat;
  int unsigned wait_cnt = 0;

  assign mem_output_valid = mem_load_request && (use_random ? mem_rnd : (wait_cnt >= lat));
  assign mem_instruction  = 16'h1000 + {4'h0, mem_address};

  always @(posedge clk) begin
    if (!mem_load_request || mem_output_valid) wait_cnt <= 0;
    else                                       wait_cnt <= wait_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched entries plus fetch/discard bookkeeping
  typedef struct packed {
    logic [15:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t      q[$];
  bit          m_run;
  bit          m_disc;
  logic [31:0] m_pc;
  logic [11:0] m_saved;
  logic        e_req;
  logic [11:0] e_addr;
  logic        e_valid;
  logic [15:0] e_instr;
  logic [31:0] e_pc;

  task automatic model_reset();
    q.delete();
    m_run   = 0;
    m_disc  = 0;
    m_pc    = '0;
    m_saved = '0;
  endtask

  task automatic model_check();
    e_req   = m_disc || (m_run && (q.size() < DEPTH));
    e_addr  = m_disc ? m_saved : (m_run ? m_pc[12:1] : 12'h000);
    e_valid = (q.size() != 0) && !redirect_valid;
    e_instr = e_valid ? q[0].instr : 16'hBF00;
    e_pc    = e_valid ? q[0].pc : 32'h0;
    chk("req",   64'(mem_load_request),  64'(e_req));
    chk("addr",  64'(mem_address),       64'(e_addr));
    chk("valid", 64'(instruction_valid), 64'(e_valid));
    chk("instr", 64'(instruction_out),   64'(e_instr));
    chk("pc",    64'(instruction_pc),    64'(e_pc));
    chk("fill",  64'(fill_level),        64'(q.size()));
  endtask

  task automatic model_step();
    bit do_pop;
    if (reset) begin
      model_reset();
      return;
    end
    do_pop = e_valid && !stall_decoder_in;
    if (redirect_valid) begin
      if (!m_disc && e_req && !mem_output_valid) begin
        m_disc  = 1;
        m_saved = e_addr;
      end
      q.delete();
      m_pc = redirect_pc & ~32'h1;
    end else if (m_disc) begin
      if (mem_output_valid) m_disc = 0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (e_req && mem_output_valid) begin
        q.push_back('{instr: 16'h1000 + {4'h0, e_addr}, pc: m_pc});
        m_pc = m_pc + 32'd2;
      end
    end
    m_run = 1;
  endtask

  task automatic finish_cycle();
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    finish_cycle();
  endtask

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        req;
    logic [11:0] addr;
    logic        vld;
    logic [15:0] instr;
    logic [31:0] pc;
    logic [2:0]  fill;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // zero-wait memory from reset, then a stall long enough to fill the queue
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 16'hBF00, 32'h0, 3'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 16'hBF00, 32'h0, 3'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 16'hBF00, 32'h0, 3'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 12'h001, 1'b1, 16'h1000, 32'h0, 3'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 12'h002, 1'b1, 16'h1001, 32'h2, 3'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 12'h003, 1'b1, 16'h1002, 32'h4, 3'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 12'h004, 1'b1, 16'h1003, 32'h6, 3'd1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 12'h005, 1'b1, 16'h1003, 32'h6, 3'd2};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 12'h006, 1'b1, 16'h1003, 32'h6, 3'd3};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 12'h007, 1'b1, 16'h1003, 32'h6, 3'd4};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 12'h007, 1'b1, 16'h1003, 32'h6, 3'd4};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 12'h007, 1'b1, 16'h1004, 32'h8, 3'd3};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 12'h008, 1'b1, 16'h1005, 32'hA, 3'd3};

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; stall_decoder_in = 1'b0;
    use_random = 1'b0; mem_rnd = 1'b0; lat = 0;
    model_reset();
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      reset            = vecs[i].rst;
      stall_decoder_in = vecs[i].stall;
      @(negedge clk);
      chk("tbl_req",   64'(mem_load_request),  64'(vecs[i].req));
      chk("tbl_addr",  64'(mem_address),       64'(vecs[i].addr));
      chk("tbl_valid", 64'(instruction_valid), 64'(vecs[i].vld));
      chk("tbl_instr", 64'(instruction_out),   64'(vecs[i].instr));
      chk("tbl_pc",    64'(instruction_pc),    64'(vecs[i].pc));
      chk("tbl_fill",  64'(fill_level),        64'(vecs[i].fill));
      finish_cycle();
    end

    // three cycles per response: address held, count moves only on valid
    reset = 1'b1; lat = 2; stall_decoder_in = 1'b0;
    cycle();
    reset = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      chk("lat_req",  64'(mem_load_request), 64'(1));
      chk("lat_addr", 64'(mem_address),      64'(0));
      chk("lat_fill", 64'(fill_level),       64'(0));
      cycle();
    end
    chk("lat_first_instr", 64'(instruction_out), 64'h1000);
    chk("lat_next_addr",   64'(mem_address),     64'(1));

    // redirect with nothing owed by memory
    reset = 1'b1; lat = 0; stall_decoder_in = 1'b1;
    cycle();
    reset = 1'b0;
    n = 0;
    while (fill_level != 3'd3 && n < 20) begin cycle(); n++; end
    chk("rd_reach_fill3", 64'(fill_level), 64'(3));
    redirect_valid = 1'b1; redirect_pc = 32'h41;
    cycle();
    redirect_valid = 1'b0; stall_decoder_in = 1'b0;
    chk("rd_fill",  64'(fill_level),  64'(0));
    chk("rd_addr",  64'(mem_address), 64'h20);
    cycle();
    chk("rd_valid", 64'(instruction_valid), 64'(1));
    chk("rd_pc",    64'(instruction_pc),    64'h40);
    chk("rd_instr", 64'(instruction_out),   64'h1020);

    // redirect while a slow request to address 5 is outstanding
    reset = 1'b1; lat = 2;
    cycle();
    reset = 1'b0;
    n = 0;
    while (!(mem_address == 12'h005 && mem_load_request && wait_cnt == 0) && n < 60) begin
      cycle(); n++;
    end
    chk("dis_reach", 64'(n < 60), 64'(1));
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    cycle();
    redirect_valid = 1'b0;
    n = 0;
    while (mem_address == 12'h005 && n < 10) begin
      chk("dis_req",     64'(mem_load_request),  64'(1));
      chk("dis_novalid", 64'(instruction_valid), 64'(0));
      cycle(); n++;
    end
    chk("dis_hold_cycles", 64'(n), 64'(2));
    chk("dis_new_addr",    64'(mem_address), 64'h40);
    n = 0;
    while (!instruction_valid && n < 20) begin cycle(); n++; end
    chk("dis_first_pc",    64'(instruction_pc),  64'h80);
    chk("dis_first_instr", 64'(instruction_out), 64'h1040);

    // reset with a nearly full queue and a request pending
    reset = 1'b1; stall_decoder_in = 1'b1;
    cycle();
    reset = 1'b0;
    n = 0;
    while (!(fill_level == 3'd3 && mem_load_request && wait_cnt == 1) && n < 60) begin
      cycle(); n++;
    end
    chk("rst_reach", 64'(n < 60), 64'(1));
    reset = 1'b1;
    cycle();
    chk("rst_req",   64'(mem_load_request),  64'(0));
    chk("rst_addr",  64'(mem_address),       64'(0));
    chk("rst_valid", 64'(instruction_valid), 64'(0));
    chk("rst_instr", 64'(instruction_out),   64'hBF00);
    chk("rst_pc",    64'(instruction_pc),    64'(0));
    chk("rst_fill",  64'(fill_level),        64'(0));
    reset = 1'b0; stall_decoder_in = 1'b0;
    for (int i = 0; i < 10; i++) cycle();

    // random traffic against the model
    use_random = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      reset            = ($urandom_range(0, 99) == 0);
      redirect_valid   = ($urandom_range(0, 19) == 0);
      redirect_pc      = $urandom;
      stall_decoder_in = ($urandom_range(0, 2) == 0);
      mem_rnd          = ($urandom_range(0, 1) == 1);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
